qdr_user_app_responder: RTL and testbench



---
 rtl/qdr_user_app_responder_if.sv | 26 ++
 rtl/qdr_user_app_responder.sv | 156 +++++++++++++++
 tb/tb_qdr_user_app_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/qdr_user_app_responder_if.sv
// QDR user-application command/response bundle between the dflow generator core
// (master) and the responder standing in for the QDR controller (slave).
interface qdr_user_app_responder_if #(
  parameter int DATA_WIDTH = 144,
  parameter int ADDR_WIDTH = 19
);
  logic                  user_app_wr_cmd;
  logic [ADDR_WIDTH-1:0] user_app_wr_addr;
  logic [DATA_WIDTH-1:0] user_app_wr_data;
  logic                  user_app_rd_cmd;
  logic [ADDR_WIDTH-1:0] user_app_rd_addr;
  logic                  user_app_rd_valid;
  logic [DATA_WIDTH-1:0] user_app_rd_data;

  modport master (
    output user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
    output user_app_rd_cmd, user_app_rd_addr,
    input  user_app_rd_valid, user_app_rd_data
  );

  modport slave (
    input  user_app_wr_cmd, user_app_wr_addr, user_app_wr_data,
    input  user_app_rd_cmd, user_app_rd_addr,
    output user_app_rd_valid, user_app_rd_data
  );
endinterface

// File: rtl/qdr_user_app_responder.sv
// On-chip QDR user-app responder: calibration delay, word array, fixed-latency reads.
// Optional feature macro QDR_RESP_STATS_EN adds wr_count/rd_count/rd_outstanding outputs.
module qdr_user_app_responder #(
  parameter int DATA_WIDTH     = 144,
  parameter int ADDR_WIDTH     = 19,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 256
) (
  input  logic                     qdr_clk,
  input  logic                     resetn,
  qdr_user_app_responder_if.slave  app,
  output logic                     init_calib_complete,
  output logic                     addr_oob_err
`ifdef QDR_RESP_STATS_EN
  ,
  output logic [31:0]              wr_count,
  output logic [31:0]              rd_count,
  output logic [5:0]               rd_outstanding
`endif
);

  localparam int CNT_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_CALIB = 1'b0,
    ST_READY = 1'b1
  } calib_state_t;

  // Any address bit above the implemented array depth counts as out of range.
  function automatic logic upper_nonzero(input logic [ADDR_WIDTH-1:0] addr);
    return |(addr >> MEM_ADDR_WIDTH);
  endfunction

  calib_state_t          state_r;
  logic [CNT_W-1:0]      calib_cnt_r;
  logic                  init_calib_r;
  logic                  oob_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  oob_hit_s;
  logic [DATA_WIDTH-1:0] mem_r [2**MEM_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_word_r;
  logic [DATA_WIDTH-1:0] pipe_data_r [1:RD_LATENCY];
  logic [RD_LATENCY:0]   vld_r;

  // Calibration FSM: count CALIB_CYCLES cycles, then hold READY until reset.
  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      state_r      <= ST_CALIB;
      calib_cnt_r  <= {CNT_W{1'b0}};
      init_calib_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CALIB: begin
          if (calib_cnt_r == CALIB_LAST) begin
            state_r      <= ST_READY;
            init_calib_r <= 1'b1;
          end else begin
            calib_cnt_r  <= calib_cnt_r + CNT_W'(1);
          end
        end
        ST_READY: begin
          init_calib_r <= 1'b1;
        end
        default: begin
          state_r      <= ST_CALIB;
          calib_cnt_r  <= {CNT_W{1'b0}};
          init_calib_r <= 1'b0;
        end
      endcase
    end
  end

  // Command qualification: nothing is acted on until calibration has completed.
  always_comb begin
    wr_acc_s  = init_calib_r & app.user_app_wr_cmd;
    rd_acc_s  = init_calib_r & app.user_app_rd_cmd;
    oob_hit_s = (wr_acc_s & upper_nonzero(app.user_app_wr_addr)) |
                (rd_acc_s & upper_nonzero(app.user_app_rd_addr));
  end

  // Word array: read-before-write on a shared address; not reset so data survives resetn.
  always_ff @(posedge qdr_clk) begin
    if (wr_acc_s) begin
      mem_r[app.user_app_wr_addr[MEM_ADDR_WIDTH-1:0]] <= app.user_app_wr_data;
    end
    rd_word_r <= mem_r[app.user_app_rd_addr[MEM_ADDR_WIDTH-1:0]];
  end

  // Read return pipeline; data is zeroed wherever its valid bit is clear.
  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      vld_r <= {(RD_LATENCY+1){1'b0}};
      for (int i = 1; i <= RD_LATENCY; i++) begin
        pipe_data_r[i] <= ZERO_WORD;
      end
    end else begin
      vld_r          <= {vld_r[RD_LATENCY-1:0], rd_acc_s};
      pipe_data_r[1] <= vld_r[0] ? rd_word_r : ZERO_WORD;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        pipe_data_r[i] <= vld_r[i-1] ? pipe_data_r[i-1] : ZERO_WORD;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      oob_r <= 1'b0;
    end else if (oob_hit_s) begin
      oob_r <= 1'b1;
    end else begin
      oob_r <= oob_r;
    end
  end

  assign init_calib_complete   = init_calib_r;
  assign addr_oob_err          = oob_r;
  assign app.user_app_rd_valid = vld_r[RD_LATENCY];
  assign app.user_app_rd_data  = pipe_data_r[RD_LATENCY];

`ifdef QDR_RESP_STATS_EN
  logic [31:0] wr_count_r;
  logic [31:0] rd_count_r;
  logic [5:0]  rd_out_r;

  // Saturating command counters; outstanding = valid bits not yet at the output stage.
  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      wr_count_r <= 32'd0;
      rd_count_r <= 32'd0;
      rd_out_r   <= 6'd0;
    end else begin
      if (wr_acc_s && (wr_count_r != 32'hFFFF_FFFF)) begin
        wr_count_r <= wr_count_r + 32'd1;
      end else begin
        wr_count_r <= wr_count_r;
      end
      if (rd_acc_s && (rd_count_r != 32'hFFFF_FFFF)) begin
        rd_count_r <= rd_count_r + 32'd1;
      end else begin
        rd_count_r <= rd_count_r;
      end
      rd_out_r <= rd_out_r + {5'd0, rd_acc_s} - {5'd0, vld_r[RD_LATENCY-1]};
    end
  end

  assign wr_count       = wr_count_r;
  assign rd_count       = rd_count_r;
  assign rd_outstanding = rd_out_r;
`endif

endmodule

// File: tb/tb_qdr_user_app_responder.sv
// Randomized scoreboard bench for qdr_user_app_responder against a queue/array reference model.
module tb_qdr_user_app_responder;

  localparam int DW    = 144;
  localparam int AW    = 19;
  localparam int MAW   = 12;
  localparam int LAT   = 8;
  localparam int CALIB = 256;

  typedef struct {
    int            due;
    bit            known;
    logic [DW-1:0] data;
  } exp_t;

  logic qdr_clk = 1'b0;
  logic resetn  = 1'b0;
  logic init_calib_complete;
  logic addr_oob_err;
`ifdef QDR_RESP_STATS_EN
  logic [31:0] wr_count;
  logic [31:0] rd_count;
  logic [5:0]  rd_outstanding;
`endif

  qdr_user_app_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) app ();

  qdr_user_app_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW),
    .RD_LATENCY(LAT), .CALIB_CYCLES(CALIB)
  ) dut (
    .qdr_clk            (qdr_clk),
    .resetn             (resetn),
    .app                (app.slave),
    .init_calib_complete(init_calib_complete),
    .addr_oob_err       (addr_oob_err)
`ifdef QDR_RESP_STATS_EN
    ,
    .wr_count           (wr_count),
    .rd_count           (rd_count),
    .rd_outstanding     (rd_outstanding)
`endif
  );

  always #5 qdr_clk = ~qdr_clk;

  int            vectors     = 0;
  int            miscompares = 0;
  int            edge_cnt    = 0;
  int            last_rst    = 0;
  bit            oob_m       = 1'b0;
  int            wr_m        = 0;
  int            rd_m        = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  exp_t          mon_e;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, got, exp, edge_cnt);
    end
  endtask

  function automatic bit is_oob(input logic [AW-1:0] a);
    return (a >> MAW) != 0;
  endfunction

  // One clock edge: the model reacts to exactly what the DUT sampled.
  task automatic tick();
    int idx;
    @(posedge qdr_clk);
    edge_cnt++;
    if (!resetn) begin
      last_rst = edge_cnt;
      exp_q.delete();
      oob_m = 1'b0;
      wr_m  = 0;
      rd_m  = 0;
    end else if ((edge_cnt - 1 - last_rst) >= CALIB) begin
      if (app.user_app_rd_cmd) begin
        idx = int'(app.user_app_rd_addr % (1 << MAW));
        if (ref_mem.exists(idx)) exp_q.push_back('{edge_cnt + LAT, 1'b1, ref_mem[idx]});
        else                     exp_q.push_back('{edge_cnt + LAT, 1'b0, {DW{1'b0}}});
        if (is_oob(app.user_app_rd_addr)) oob_m = 1'b1;
        rd_m++;
      end
      if (app.user_app_wr_cmd) begin
        idx = int'(app.user_app_wr_addr % (1 << MAW));
        ref_mem[idx] = app.user_app_wr_data;
        if (is_oob(app.user_app_wr_addr)) oob_m = 1'b1;
        wr_m++;
      end
    end
    #1;
  endtask

  task automatic cmd(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic r, input logic [AW-1:0] ra);
    app.user_app_wr_cmd  = w;
    app.user_app_wr_addr = wa;
    app.user_app_wr_data = wd;
    app.user_app_rd_cmd  = r;
    app.user_app_rd_addr = ra;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cmd(1'b0, 19'h0, {DW{1'b0}}, 1'b0, 19'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd(1'b1, a, d, 1'b0, 19'h0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cmd(1'b0, 19'h0, {DW{1'b0}}, 1'b1, a);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Monitor: compares every observable output once per cycle against the model.
  always @(negedge qdr_clk) begin
    int pending;
    if (edge_cnt > 0) begin
      check("init_calib_complete", DW'(init_calib_complete), DW'(bit'((edge_cnt - last_rst) >= CALIB)));
      check("addr_oob_err", DW'(addr_oob_err), DW'(oob_m));
      if (app.user_app_rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_spurious", DW'(app.user_app_rd_valid), DW'(1'b0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_valid_edge", DW'(edge_cnt), DW'(mon_e.due));
          if (mon_e.known) check("rd_data", app.user_app_rd_data, mon_e.data);
        end
      end else begin
        check("rd_data_idle", app.user_app_rd_data, {DW{1'b0}});
        if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
          mon_e = exp_q.pop_front();
          check("rd_valid_missing", DW'(app.user_app_rd_valid), DW'(1'b1));
        end
      end
`ifdef QDR_RESP_STATS_EN
      pending = 0;
      foreach (exp_q[i]) if (exp_q[i].due > edge_cnt) pending++;
      check("wr_count", DW'(wr_count), DW'(wr_m));
      check("rd_count", DW'(rd_count), DW'(rd_m));
      check("rd_outstanding", DW'(rd_outstanding), DW'(pending));
`else
      pending = 0;
`endif
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic          w, r;
    app.user_app_wr_cmd  = 1'b0;
    app.user_app_wr_addr = 19'h0;
    app.user_app_wr_data = {DW{1'b0}};
    app.user_app_rd_cmd  = 1'b0;
    app.user_app_rd_addr = 19'h0;

    idle(3);
    resetn = 1'b1;
    // Commands during calibration must be ignored, including out-of-range ones.
    idle(100);
    rd(19'h010);
    wr(19'h7_0010, {18{8'h5A}});
    idle(CALIB + 4 - 102);

    wr(19'h010, {18{8'hA5}});
    idle(1);
    rd(19'h010);
    idle(12);

    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(i + 1));
    for (int i = 3; i >= 0; i--) rd(AW'(i));
    idle(12);

    wr(19'h020, DW'(8'h11));
    cmd(1'b1, 19'h020, DW'(8'h22), 1'b1, 19'h020);
    rd(19'h020);
    idle(12);

    wr(19'h01005, DW'(8'h77));
    rd(19'h005);
    idle(12);

    for (int i = 0; i < 1500; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a[AW-1:MAW] = 7'($urandom);
      cmd(w, a, rand_word(), r, AW'($urandom_range(0, 31)));
    end
    idle(12);

    // Reset with reads in flight; array contents must survive.
    rd(19'h010);
    rd(19'h003);
    rd(19'h020);
    idle(3);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    idle(50);
    wr(19'h003, rand_word());
    idle(CALIB + 4 - 51);
    rd(19'h010);
    rd(19'h003);
    rd(19'h020);
    rd(19'h005);
    idle(LAT + 8);

    check("drain", DW'(exp_q.size()), {DW{1'b0}});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
